// File: rtl/bht_update_queue.sv
// Branch-outcome queue between the branch unit and the private-history BHT.
// Resolved conditional branches are buffered in a small circular FIFO and
// replayed one per permitted cycle as registered single-cycle update pulses.
// When the queue is full and nothing drains, the oldest entry is dropped
// and a saturating diagnostic counter records the loss.
module bht_update_queue #(
   parameter int VLEN          = 64,
   parameter int DEPTH         = 4,
   parameter int OVF_CNT_WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       resolved_valid_i,
   input  logic                       resolved_is_cond_i,
   input  logic [VLEN-1:0]            resolved_pc_i,
   input  logic                       resolved_taken_i,
   input  logic                       drain_en_i,
   output logic                       bht_update_valid_o,
   output logic [VLEN-1:0]            bht_update_pc_o,
   output logic                       bht_update_taken_o,
   output logic [$clog2(DEPTH):0]     occupancy_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [OVF_CNT_WIDTH-1:0]   overflow_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Entry storage; contents are only meaningful between head and tail,
   // so the array carries no reset.
   logic [VLEN-1:0]          pc_mem    [DEPTH];
   logic                     taken_mem [DEPTH];

   logic [PTR_W-1:0]         head;
   logic [PTR_W-1:0]         tail;
   logic [CNT_W-1:0]         count;
   logic [OVF_CNT_WIDTH-1:0] ovf_cnt;

   logic                     upd_vld_p1;
   logic [VLEN-1:0]          upd_pc_p1;
   logic                     upd_taken_p1;

   logic                     full;
   logic                     empty;
   logic                     enq;
   logic                     deq;

   // Queue status and handshake decisions, all from registered state.
   always_comb begin
      full  = (count == FULL_CNT);
      empty = (count == '0);
      enq   = resolved_valid_i & resolved_is_cond_i & ~flush_i;
      deq   = drain_en_i & ~empty & ~flush_i;
   end

   // Write the incoming outcome at the tail; when full this is the head slot,
   // and a same-edge dequeue still reads the old head contents.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         pc_mem[tail]    <= resolved_pc_i;
         taken_mem[tail] <= resolved_taken_i;
      end
   end

   // Pointer, occupancy, overflow and output-pulse control.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         ovf_cnt      <= '0;
         upd_vld_p1   <= 1'b0;
         upd_pc_p1    <= '0;
         upd_taken_p1 <= 1'b0;
      end else if (flush_i) begin
         // Overflow count is diagnostic and survives a flush.
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         upd_vld_p1 <= 1'b0;
      end else begin
         upd_vld_p1 <= deq;
         if (deq) begin
            upd_pc_p1    <= pc_mem[head];
            upd_taken_p1 <= taken_mem[head];
         end
         if (enq && deq) begin
            head <= head + PTR_W'(1);
            tail <= tail + PTR_W'(1);
         end else if (enq) begin
            tail <= tail + PTR_W'(1);
            if (full) begin
               // Drop-oldest: the new entry replaced the head slot.
               head <= head + PTR_W'(1);
               if (ovf_cnt != '1)
                  ovf_cnt <= ovf_cnt + OVF_CNT_WIDTH'(1);
            end else begin
               count <= count + CNT_W'(1);
            end
         end else if (deq) begin
            head  <= head + PTR_W'(1);
            count <= count - CNT_W'(1);
         end
      end
   end

   // Drive outputs straight from registers.
   always_comb begin
      bht_update_valid_o = upd_vld_p1;
      bht_update_pc_o    = upd_pc_p1;
      bht_update_taken_o = upd_taken_p1;
      occupancy_o        = count;
      full_o             = full;
      empty_o            = empty;
      overflow_cnt_o     = ovf_cnt;
   end

endmodule

// File: tb/tb_bht_update_queue.sv
// Bench for bht_update_queue: directed scenarios plus random traffic,
// checked against a queue-based model of the buffering rules.
module tb_bht_update_queue;

   localparam int VLEN  = 64;
   localparam int DEPTH = 4;
   localparam int OVF_W = 8;
   localparam int OVF_MAX = (1 << OVF_W) - 1;

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic              flush_i = 1'b0;
   logic              resolved_valid_i = 1'b0;
   logic              resolved_is_cond_i = 1'b0;
   logic [VLEN-1:0]   resolved_pc_i = '0;
   logic              resolved_taken_i = 1'b0;
   logic              drain_en_i = 1'b0;
   logic              bht_update_valid_o;
   logic [VLEN-1:0]   bht_update_pc_o;
   logic              bht_update_taken_o;
   logic [$clog2(DEPTH):0] occupancy_o;
   logic              full_o;
   logic              empty_o;
   logic [OVF_W-1:0]  overflow_cnt_o;

   bht_update_queue #(.VLEN(VLEN), .DEPTH(DEPTH), .OVF_CNT_WIDTH(OVF_W)) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .flush_i            (flush_i),
      .resolved_valid_i   (resolved_valid_i),
      .resolved_is_cond_i (resolved_is_cond_i),
      .resolved_pc_i      (resolved_pc_i),
      .resolved_taken_i   (resolved_taken_i),
      .drain_en_i         (drain_en_i),
      .bht_update_valid_o (bht_update_valid_o),
      .bht_update_pc_o    (bht_update_pc_o),
      .bht_update_taken_o (bht_update_taken_o),
      .occupancy_o        (occupancy_o),
      .full_o             (full_o),
      .empty_o            (empty_o),
      .overflow_cnt_o     (overflow_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [VLEN-1:0] pc;
      logic            taken;
   } ent_t;

   ent_t            mq[$];
   logic            m_valid;
   logic [VLEN-1:0] m_pc;
   logic            m_taken;
   int              m_ovf;
   int              nvec = 0;
   int              nerr = 0;

   task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_valid = 1'b0;
      m_pc    = '0;
      m_taken = 1'b0;
      m_ovf   = 0;
   endtask

   task automatic check_all();
      check("valid",     VLEN'(bht_update_valid_o), VLEN'(m_valid));
      check("pc",        bht_update_pc_o,           m_pc);
      check("taken",     VLEN'(bht_update_taken_o), VLEN'(m_taken));
      check("occupancy", VLEN'(occupancy_o),        VLEN'(mq.size()));
      check("full",      VLEN'(full_o),             VLEN'(mq.size() == DEPTH));
      check("empty",     VLEN'(empty_o),            VLEN'(mq.size() == 0));
      check("overflow",  VLEN'(overflow_cnt_o),     VLEN'(m_ovf));
   endtask

   // One clock: drive inputs, advance the model over the edge, compare.
   task automatic step(input logic v, input logic c, input logic [VLEN-1:0] pc,
                       input logic t, input logic d, input logic f);
      ent_t e;
      resolved_valid_i   = v;
      resolved_is_cond_i = c;
      resolved_pc_i      = pc;
      resolved_taken_i   = t;
      drain_en_i         = d;
      flush_i            = f;
      @(posedge clk);
      if (f) begin
         mq.delete();
         m_valid = 1'b0;
      end else begin
         m_valid = d && (mq.size() > 0);
         if (m_valid) begin
            e = mq.pop_front();
            m_pc    = e.pc;
            m_taken = e.taken;
         end
         if (v && c) begin
            if (mq.size() == DEPTH) begin
               void'(mq.pop_front());
               if (m_ovf < OVF_MAX) m_ovf++;
            end
            e.pc    = pc;
            e.taken = t;
            mq.push_back(e);
         end
      end
      #1;
      check_all();
   endtask

   task automatic idle(input logic d);
      step(1'b0, 1'b0, '0, 1'b0, d, 1'b0);
   endtask

   task automatic push(input logic [VLEN-1:0] pc, input logic t, input logic d);
      step(1'b1, 1'b1, pc, t, d, 1'b0);
   endtask

   initial begin
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst_i = 1'b0;

      // 1: single update with minimum latency
      push(64'h8000_0010, 1'b1, 1'b1);
      check("t1_no_pulse_e1", VLEN'(bht_update_valid_o), VLEN'(0));
      idle(1'b1);
      check("t1_pulse_pc", bht_update_pc_o, 64'h8000_0010);
      idle(1'b1);
      check("t1_pulse_gone", VLEN'(bht_update_valid_o), VLEN'(0));

      // 2: unconditional branches are filtered
      step(1'b1, 1'b0, 64'h100, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      // 3: drop-oldest overflow, then in-order drain
      for (int i = 1; i <= 6; i++) push(VLEN'(i * 16), i[0], 1'b0);
      check("t3_ovf", VLEN'(overflow_cnt_o), VLEN'(2));
      for (int i = 0; i < 5; i++) idle(1'b1);

      // 4: full with simultaneous enqueue and dequeue
      for (int i = 1; i <= 4; i++) push(VLEN'(i * 16), 1'b0, 1'b0);
      push(64'h50, 1'b1, 1'b1);
      check("t4_pc", bht_update_pc_o, 64'h10);
      check("t4_occ", VLEN'(occupancy_o), VLEN'(4));

      // 5: flush discards queue and same-cycle input, keeps overflow count
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 3; i++) push(VLEN'(i * 16 + 256), 1'b1, 1'b0);
      step(1'b1, 1'b1, 64'h70, 1'b1, 1'b1, 1'b1);
      check("t5_ovf_kept", VLEN'(overflow_cnt_o), VLEN'(2));
      for (int i = 0; i < 3; i++) idle(1'b1);

      // 6: asynchronous reset while a pulse is visible
      push(64'hA0, 1'b1, 1'b0);
      push(64'hB0, 1'b0, 1'b0);
      idle(1'b1);
      check("t6_pulse_before", VLEN'(bht_update_valid_o), VLEN'(1));
      #2 rst_i = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_i = 1'b0;

      // Overflow counter saturation
      for (int i = 0; i < OVF_MAX + DEPTH + 10; i++)
         push(VLEN'($urandom), 1'b1, 1'b0);
      check("sat_ovf", VLEN'(overflow_cnt_o), VLEN'(OVF_MAX));

      // Random traffic
      for (int i = 0; i < 3000; i++)
         step(1'b1 & ($urandom_range(0, 3) != 0), $urandom_range(0, 4) != 0,
              {$urandom, $urandom}, 1'($urandom), 1'($urandom),
              $urandom_range(0, 40) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/bht_update_queue.md
Name: bht_update_queue

Overview:
- Buffers resolved conditional-branch outcomes from the branch unit and replays them as single-cycle BHT update pulses into the private-history BHT (bht2lvl-style consumer of bht_update_t: valid, pc, taken).
- Sits directly upstream of the BHT.
- Decouples execute-stage resolution bursts from the BHT write port.
- Suppresses updates while the frontend holds drain off.

Parameters:
- VLEN, 64, width of branch PC.
- DEPTH, 4, queue entries; power of two, >=2.
- OVF_CNT_WIDTH, 8, width of the saturating overflow counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  discard all queued entries and any pending output.
- resolved_valid_i  in  1  branch resolved this cycle.
- resolved_is_cond_i  in  1  resolved instruction is a conditional branch.
- resolved_pc_i  in  VLEN  PC of resolved branch.
- resolved_taken_i  in  1  actual outcome.
- drain_en_i  in  1  permit one dequeue this cycle.
- bht_update_valid_o  out  1  update pulse to BHT.
- bht_update_pc_o  out  VLEN  update PC.
- bht_update_taken_o  out  1  update outcome.
- occupancy_o  out  $clog2(DEPTH)+1  entries held.
- full_o  out  1  occupancy_o == DEPTH.
- empty_o  out  1  occupancy_o == 0.
- overflow_cnt_o  out  OVF_CNT_WIDTH  dropped-entry count, saturating.

Behaviour:
- Reset (async, immediate): head, tail and count = 0; all outputs 0; overflow_cnt_o = 0; empty_o = 1.
- Enqueue condition: enq = resolved_valid_i & resolved_is_cond_i & !flush_i. Unconditional branches and jumps are ignored.
- Dequeue condition: deq = drain_en_i & !empty_o & !flush_i. Evaluated on the registered state; there is no same-cycle bypass.
- Output register: on deq, the head entry loads into {pc, taken} and bht_update_valid_o = 1 for exactly one cycle. Otherwise bht_update_valid_o = 0 and pc/taken hold their last value.
- Latency: an entry enqueued at edge N is dequeued at the earliest at edge N+1. The pulse is visible from N+1 to N+2, so minimum latency is 2 cycles from input to update.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- Full, enq without deq (drop-oldest):
  - the tail entry overwrites the head slot; head and tail both advance; count stays DEPTH;
  - overflow_cnt increments and saturates at all-ones.
- Full, enq with deq: normal dequeue plus enqueue; no drop; count stays DEPTH.
- Empty, enq with drain_en_i: entry is stored, no pulse this cycle; count goes to 1.
- Flush: at the next edge, head = tail = count = 0 and bht_update_valid_o = 0. The same-cycle input is discarded. overflow_cnt is NOT cleared (diagnostic; reset only).
- Reset mid-burst: all state clears asynchronously. bht_update_valid_o drops without waiting for a clock edge.
- occupancy_o, full_o and empty_o are registered-state derived. No combinational path from inputs to outputs.

Test Plan:
1. Single update: reset, then drain_en_i = 1; enq pc = 0x8000_0010, taken = 1 at edge 1 → bht_update_valid_o high only in cycle 2–3 with pc 0x8000_0010, taken 1; occupancy returns to 0.
2. Filtering: resolved_valid_i = 1, resolved_is_cond_i = 0, pc 0x100 → occupancy stays 0; no pulse.
3. Overflow: DEPTH = 4, drain_en_i = 0; enq pcs 0x10, 0x20, 0x30, 0x40, 0x50, 0x60 → full_o = 1, overflow_cnt_o = 2. Then drain → pulses in order 0x30, 0x40, 0x50, 0x60.
4. Full with simultaneous enq/deq: 4 queued (0x10–0x40), drain_en_i = 1 while enq 0x50 → pulse 0x10, occupancy stays 4, overflow_cnt_o unchanged.
5. Flush: 3 entries queued, flush_i pulsed with enq 0x70 → next cycle occupancy 0, empty_o = 1, no pulse, overflow_cnt_o retains its prior value, 0x70 never emitted.
6. Async reset mid-drain: assert rst_i between clock edges while bht_update_valid_o = 1 → all outputs 0 before the next edge; overflow_cnt_o = 0.
